// File: rtl/pink_noise_pkg.sv
// Shared constants, FSM state type and helper functions for the pink-noise source.
// Macro PINK_WHITE_ROW_EN adds a per-sample white term (one extra sum bit).
package pink_noise_pkg;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] SEED_STRIDE = 32'h9E37_79B9;
  localparam int          GAIN_FRAC   = 7;

`ifdef PINK_WHITE_ROW_EN
  localparam bit WHITE_EN = 1'b1;
`else
  localparam bit WHITE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Right-shifting Galois step: the bit shifted out folds the taps back in.
  function automatic logic [31:0] lfsr32_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Exact width of a running sum of num_rows signed row values (plus white term).
  function automatic int sum_width(input int row_bits, input int num_rows, input bit white);
    return row_bits + $clog2(num_rows + 1) + (white ? 1 : 0);
  endfunction

  function automatic logic [31:0] lfsr_seed(input logic [31:0] base, input int ch);
    logic [31:0] s;
    s = base + SEED_STRIDE * 32'(ch);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/pink_noise_multichannel_ctz.sv
// Trailing-zero priority encoder over the low sample-count bits, saturating at NUM_ROWS-1.
module pink_ctz #(
  parameter int NUM_ROWS = 12,
  parameter int K_W      = 4
) (
  input  logic [NUM_ROWS-2:0] count_lo,
  output logic [K_W-1:0]      k
);

  // Scanning downward lets the lowest set bit win; no set bit (or a zero count) saturates.
  always_comb begin
    k = K_W'(NUM_ROWS - 1);
    for (int i = NUM_ROWS - 2; i >= 0; i--) begin
      if (count_lo[i]) k = K_W'(i);
    end
  end

endmodule

// File: rtl/pink_noise_multichannel.sv
// Multi-channel Voss-McCartney pink-noise source with a time-multiplexed row datapath.
// Macro PINK_WHITE_ROW_EN adds a white term per channel per sample.
module pink_noise_multichannel
  import pink_noise_pkg::*;
#(
  parameter int          WIDTH     = 18,
  parameter int          NUM_ROWS  = 12,
  parameter int          ROW_BITS  = 12,
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] SEED_BASE = 32'hACE1_2468,
  parameter int          GAIN_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic [GAIN_W-1:0]       gain,
  output logic [NUM_CH*WIDTH-1:0] noise_out,
  output logic                    noise_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int SUM_W      = sum_width(ROW_BITS, NUM_ROWS, WHITE_EN);
  localparam int K_W        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W_RAW = SUM_W + GAIN_W + 1;
  localparam int PROD_W     = (PROD_W_RAW > WIDTH) ? PROD_W_RAW : WIDTH + 1;
  localparam int CNT_W      = 16;

  localparam logic signed [PROD_W-1:0] OUT_MAX = {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] OUT_MIN = {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_e                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [K_W-1:0]             k_q, k_d, k_next;
  logic [GAIN_W-1:0]          gain_q, gain_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [31:0]                lfsr_q [NUM_CH];
  logic [31:0]                lfsr_d [NUM_CH];
  logic signed [ROW_BITS-1:0] row_q  [NUM_CH][NUM_ROWS];
  logic signed [ROW_BITS-1:0] row_d  [NUM_CH][NUM_ROWS];
  logic signed [SUM_W-1:0]    sum_q  [NUM_CH];
  logic signed [SUM_W-1:0]    sum_d  [NUM_CH];
  logic [NUM_CH*WIDTH-1:0]    noise_q, noise_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;

  logic [31:0]                step1;
  logic signed [ROW_BITS-1:0] row_new;

  assign step1   = lfsr32_step(lfsr_q[ch_q]);
  assign row_new = step1[ROW_BITS-1:0];

`ifdef PINK_WHITE_ROW_EN
  logic [31:0]                step2;
  logic signed [ROW_BITS-1:0] white_q [NUM_CH];
  logic signed [ROW_BITS-1:0] white_d [NUM_CH];
  assign step2 = lfsr32_step(step1);
`endif

  pink_ctz #(
    .NUM_ROWS (NUM_ROWS),
    .K_W      (K_W)
  ) u_ctz (
    .count_lo (cnt_q[NUM_ROWS-2:0]),
    .k        (k_next)
  );

  // Full-precision product, floor shift, then clamp to the signed output range.
  function automatic logic [WIDTH-1:0] scale_sat(input logic signed [SUM_W-1:0] acc,
                                                 input logic [GAIN_W-1:0] g);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(acc) * PROD_W'($signed({1'b0, g}));
    prod = prod >>> GAIN_FRAC;
    if (prod > OUT_MAX)      prod = OUT_MAX;
    else if (prod < OUT_MIN) prod = OUT_MIN;
    return prod[WIDTH-1:0];
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q (pulses from 0) so no branch can leave one unassigned and infer a latch.
    state_d   = state_q;
    ch_d      = ch_q;
    k_d       = k_q;
    gain_d    = gain_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    row_d     = row_q;
    sum_d     = sum_q;
    noise_d   = noise_q;
    valid_d   = 1'b0;
    overrun_d = clk_en && (state_q != IDLE);
`ifdef PINK_WHITE_ROW_EN
    white_d   = white_q;
`endif

    case (state_q)
      IDLE: begin
        if (clk_en) begin
          state_d = RUN;
          ch_d    = '0;
          k_d     = k_next;
          gain_d  = gain;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      RUN: begin
        sum_d[ch_q]      = sum_q[ch_q] - SUM_W'(row_q[ch_q][k_q]) + SUM_W'(row_new);
        row_d[ch_q][k_q] = row_new;
`ifdef PINK_WHITE_ROW_EN
        lfsr_d[ch_q]  = step2;
        white_d[ch_q] = step2[ROW_BITS-1:0];
`else
        lfsr_d[ch_q] = step1;
`endif
        if (ch_q == CH_W'(NUM_CH - 1)) state_d = OUT;
        else                           ch_d    = ch_q + 1'b1;
      end
      OUT: begin
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef PINK_WHITE_ROW_EN
          noise_d[c*WIDTH +: WIDTH] = scale_sat(sum_q[c] + SUM_W'(white_q[c]), gain_q);
`else
          noise_d[c*WIDTH +: WIDTH] = scale_sat(sum_q[c], gain_q);
`endif
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      k_q       <= '0;
      gain_q    <= '0;
      cnt_q     <= '0;
      noise_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        lfsr_q[c] <= lfsr_seed(SEED_BASE, c);
        sum_q[c]  <= '0;
`ifdef PINK_WHITE_ROW_EN
        white_q[c] <= '0;
`endif
        // NOTE: row storage is reset too; the incremental sum is only correct if rows and sum start consistent.
        for (int r = 0; r < NUM_ROWS; r++) row_q[c][r] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge _d values together.
      state_q   <= state_d;
      ch_q      <= ch_d;
      k_q       <= k_d;
      gain_q    <= gain_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      row_q     <= row_d;
      sum_q     <= sum_d;
      noise_q   <= noise_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef PINK_WHITE_ROW_EN
      white_q   <= white_d;
`endif
    end
  end

  assign noise_out   = noise_q;
  assign noise_valid = valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pink_noise_multichannel.sv
// Directed bench: reference model of rows/sums/LFSRs, a narrow-output twin for saturation.
module tb_pink_noise_multichannel;

  localparam int          WIDTH     = 18;
  localparam int          SAT_W     = 12;
  localparam int          NUM_ROWS  = 12;
  localparam int          NUM_CH    = 4;
  localparam logic [31:0] SEED_BASE = 32'hACE1_2468;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    clk_en = 1'b0;
  logic [7:0]              gain = 8'd0;
  logic [NUM_CH*WIDTH-1:0] noise_out;
  logic                    noise_valid, busy, overrun;
  logic [NUM_CH*SAT_W-1:0] sat_out;
  logic                    sat_valid, sat_busy, sat_overrun;

  pink_noise_multichannel dut (
    .clk (clk), .rst_n (rst_n), .clk_en (clk_en), .gain (gain),
    .noise_out (noise_out), .noise_valid (noise_valid), .busy (busy), .overrun (overrun)
  );

  pink_noise_multichannel #(.WIDTH(SAT_W)) dut_sat (
    .clk (clk), .rst_n (rst_n), .clk_en (clk_en), .gain (gain),
    .noise_out (sat_out), .noise_valid (sat_valid), .busy (sat_busy), .overrun (sat_overrun)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int sat_hits   = 0;

  logic [31:0] m_lfsr [NUM_CH];
  int          m_row  [NUM_CH][NUM_ROWS];
  int          m_sum  [NUM_CH];
  int          m_cnt;
  int          m_k;
  longint      m_exp     [NUM_CH];
  longint      m_exp_sat [NUM_CH];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ 32'h8020_0003;
    return s >> 1;
  endfunction

  function automatic int m_row_val(input logic [31:0] s);
    int v;
    v = int'(s[11:0]);
    if (v >= 2048) v -= 4096;
    return v;
  endfunction

  function automatic longint m_sat(input longint v, input int w);
    longint hi;
    hi = (longint'(1) << (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_lfsr[c] = SEED_BASE + 32'(c) * 32'h9E37_79B9;
      if (m_lfsr[c] == 32'h0) m_lfsr[c] = 32'h1;
      m_sum[c] = 0;
      for (int r = 0; r < NUM_ROWS; r++) m_row[c][r] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_tick(input int g);
    longint val;
    if (m_cnt == 0) m_k = NUM_ROWS - 1;
    else begin
      m_k = 0;
      while (((m_cnt >> m_k) & 1) == 0) m_k++;
      if (m_k > NUM_ROWS - 1) m_k = NUM_ROWS - 1;
    end
    m_cnt = (m_cnt + 1) % 65536;
    for (int c = 0; c < NUM_CH; c++) begin
      m_lfsr[c] = m_step(m_lfsr[c]);
      m_sum[c]  = m_sum[c] - m_row[c][m_k] + m_row_val(m_lfsr[c]);
      m_row[c][m_k] = m_row_val(m_lfsr[c]);
      val = longint'(m_sum[c]);
`ifdef PINK_WHITE_ROW_EN
      m_lfsr[c] = m_step(m_lfsr[c]);
      val += longint'(m_row_val(m_lfsr[c]));
`endif
      m_exp[c]     = m_sat((val * g) >>> 7, WIDTH);
      m_exp_sat[c] = m_sat((val * g) >>> 7, SAT_W);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the edge that raised noise_valid.
  task automatic run_tick(input logic [7:0] g, input logic [7:0] g_after, input int exp_k, input string tag);
    int n;
    logic signed [SAT_W-1:0] s;
    gain = g;
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    gain = g_after;
    model_tick(int'(g));
    check({tag, " busy"}, busy, 1);
    check({tag, " k"}, dut.k_q, (exp_k >= 0) ? exp_k : m_k);
    n = 0;
    while (noise_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, NUM_CH + 1);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s ch%0d", tag, c), $signed(noise_out[c*WIDTH +: WIDTH]), m_exp[c]);
      s = sat_out[c*SAT_W +: SAT_W];
      check($sformatf("%s sat ch%0d", tag, c), s, m_exp_sat[c]);
      if (s == 12'sd2047 || s == -12'sd2048) sat_hits++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_k_tbl [8];
    logic [NUM_CH*WIDTH-1:0] held;
    exp_k_tbl = '{11, 0, 1, 0, 2, 0, 1, 0};

    #12;
    check("reset noise_out", noise_out, 0);
    check("reset valid", noise_valid, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    for (int t = 0; t < 8; t++) begin
      run_tick(8'd128, 8'd128, exp_k_tbl[t], $sformatf("seq%0d", t));
`ifndef PINK_WHITE_ROW_EN
      if (t == 0) begin
        check("first ch0 hand", $signed(noise_out[0 +: WIDTH]), 564);
        check("first ch1 hand", $signed(noise_out[WIDTH +: WIDTH]), -237);
      end
`endif
    end

    held = noise_out;
    repeat (4) @(posedge clk);
    #1;
    check("hold noise_out", noise_out, held);
    check("valid low between", noise_valid, 0);
    check("idle busy", busy, 0);

    run_tick(8'd0, 8'd0, -1, "gain0");
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("gain0 zero ch%0d", c), $signed(noise_out[c*WIDTH +: WIDTH]), 0);

    for (int t = 0; t < 40; t++) run_tick(8'd255, 8'd255, -1, $sformatf("g255_%0d", t));
    check("saturation reached", sat_hits > 0, 1);

    run_tick(8'd128, 8'd0, -1, "gain_midchange");
    run_tick(8'd77, 8'd77, -1, "gain77");

    // Overrun: accept at E0, second tick at E2 is ignored.
    gain = 8'd128;
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    model_tick(128);
    @(posedge clk); #1;
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    check("overrun pulse", overrun, 1);
    @(posedge clk); #1;
    check("overrun one cycle", overrun, 0);
    begin
      int n;
      n = 0;
      while (noise_valid !== 1'b1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("overrun valid latency", n, 2);
    end
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("overrun ch%0d", c), $signed(noise_out[c*WIDTH +: WIDTH]), m_exp[c]);
    run_tick(8'd128, 8'd128, -1, "after_overrun");

    // Reset while channel 2 is being processed.
    gain = 8'd128;
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre-reset ch index", dut.ch_q, 2);
    rst_n = 1'b0;
    #1;
    check("midreset noise_out", noise_out, 0);
    check("midreset valid", noise_valid, 0);
    check("midreset busy", busy, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    run_tick(8'd128, 8'd128, 11, "restart0");
`ifndef PINK_WHITE_ROW_EN
    check("restart ch0 hand", $signed(noise_out[0 +: WIDTH]), 564);
`endif
    run_tick(8'd128, 8'd128, 0, "restart1");
    run_tick(8'd128, 8'd128, 1, "restart2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pink_noise_multichannel.md
Name: pink_noise_multichannel

Overview:
Multi-channel Voss-McCartney pink-noise source. It is the parametrised successor to the single-channel fixed-row generator. Each sample tick updates exactly one octave row per channel, chosen by trailing-zero count, and keeps an incremental running sum. Each channel has its own decorrelated 32-bit LFSR, and a shared datapath is time-multiplexed across channels. Output is gain-scaled and saturated; it feeds the oscillator/stimulus mixers as background 1/f drive.

Parameters:
WIDTH, 18, output sample width per channel (signed)
NUM_ROWS, 12, octave rows per channel (legal 2..16)
ROW_BITS, 12, width of each signed row value
NUM_CH, 4, number of independent channels (legal 1..16)
SEED_BASE, 32'hACE1_2468, base LFSR seed
GAIN_W, 8, gain width, unsigned Q1.7 (128 = 1.0)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  sample tick, one-cycle pulse
gain  in  GAIN_W  output gain, Q1.7, sampled at tick acceptance
noise_out  out  NUM_CH*WIDTH  packed signed samples, channel c at [c*WIDTH +: WIDTH]
noise_valid  out  1  one-cycle pulse when noise_out updates
busy  out  1  high while FSM not IDLE
overrun  out  1  one-cycle pulse when clk_en arrives while busy

Behaviour:
- Reset (async, rst_n=0):
  - noise_out=0, noise_valid=0, busy=0, overrun=0.
  - sample_count=0, all rows and sums=0, FSM=IDLE.
  - LFSR[c] = SEED_BASE + c*32'h9E3779B9 (mod 2^32); forced to 32'h1 if zero.
- Reset mid-operation aborts the current sample immediately; no partial valid pulse.
- FSM IDLE -> RUN -> OUT -> IDLE.
  - IDLE with clk_en:
    - latch k and gain_q; enter RUN with ch=0.
    - k = ctz(sample_count), saturated to NUM_ROWS-1; sample_count=0 gives k=NUM_ROWS-1.
    - then sample_count+1 (wraps at 2^16).
  - RUN: one channel per cycle, ch=0..NUM_CH-1:
    - LFSR[ch] advances one Galois step, taps 32'h80200003.
    - new = LFSR_next[ROW_BITS-1:0] as signed.
    - sum[ch] <= sum[ch] - row[ch][k] + new; row[ch][k] <= new.
    - after ch=NUM_CH-1, go to OUT.
  - OUT:
    - per channel: scaled = (sum[ch]*gain_q) >>> 7, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
    - register all channels simultaneously; pulse noise_valid; go to IDLE.
- Latency: noise_valid is asserted NUM_CH+1 cycles after the accepting clk_en. Minimum tick spacing is NUM_CH+2 cycles.
- clk_en while busy: ignored (no count, LFSR or row change); overrun pulses the next cycle.
- Width rules:
  - sum width = ROW_BITS + clog2(NUM_ROWS+1), exact, never wraps.
  - product is full precision before the shift.
  - round toward -inf (arithmetic shift).
- noise_out holds its value between valid pulses.
- gain change mid-sample has no effect until the next accepted tick.

Optional Feature:
- Macro PINK_WHITE_ROW_EN.
  - Defined: each channel adds a white term each sample. LFSR[ch] takes a second Galois step in RUN and w = bits [ROW_BITS-1:0] of that step. w is not stored in sum. Output is (sum[ch]+w) scaled, which flattens the top octave (true Voss-McCartney). Sum width grows by 1 bit; latency is unchanged.
  - Undefined: single step per channel; output derives from sum only.

Decomposition:
- Package pink_noise_pkg holds:
  - LFSR tap constant 32'h80200003
  - seed stride 32'h9E3779B9
  - GAIN_FRAC=7
  - FSM state enum {IDLE, RUN, OUT}
  - function lfsr32_step
  - sum-width function
- One sub-module: pink_ctz, a combinational trailing-zero priority encoder over sample_count with saturation to NUM_ROWS-1. Rows are register arrays; no RAM inference is required.

Test Plan:
- Reset, gain=128, NUM_CH=4, ticks every 8 cycles -> noise_valid exactly 5 cycles after each tick. Row index sequence for the first 8 ticks is 11,0,1,0,2,0,1,0.
- gain=0 -> all channels output 0 with valid still pulsing. gain=128 -> noise_out[c] equals sum[c], bit-exact against a C reference model over 10000 samples per channel.
- WIDTH=16, gain=255, run 20000 ticks -> outputs never exceed 32767/-32768. Saturation is hit at least once, and there is no wraparound sign flip.
- Tick at cycle 0 and again at cycle 2 -> overrun pulse at cycle 3. Second tick ignored: sample_count advanced by only 1, and the next valid output matches the model.
- Assert rst_n=0 during RUN (ch=2) -> outputs are 0 immediately. After release, the sequence restarts identical to post-reset (first 3 samples match a fresh run).
- NUM_CH=4 -> channels pairwise differ in first sample. Cross-correlation over 8192 samples is below 0.05. With PINK_WHITE_ROW_EN, the model comparison passes with the white term included.
